// File: rtl/gpu_bus_interface.sv
// ---------------------------------------------------------------------------
// gpu_bus_interface
//
// CPU-facing write port of the GPU. The asynchronous chip-select strobe is
// brought into the CLK100MHz domain through two flops followed by a rising
// edge detect. The bus is captured on the detected edge and the register
// action is applied one cycle later. VRAM writes are queued and presented to
// memory with a hold-until-ack handshake.
//
// Build option:
//   GPU_WRITE_FIFO_EN  defined   -> FIFO_DEPTH-entry VRAM write queue
//                      undefined -> single holding register (depth 1)
// ---------------------------------------------------------------------------
module gpu_bus_interface #(
    parameter int VRAM_AW    = 13,
    parameter int FIFO_DEPTH = 4
) (
    input  logic               CLK100MHz,
    input  logic               rst,
    input  logic [7:0]         data,
    input  logic [3:0]         addr,
    input  logic               rw,
    input  logic               cs_clock,
    input  logic               vblank,
    output logic [VRAM_AW-1:0] vram_wr_addr,
    output logic [7:0]         vram_wr_data,
    output logic               vram_we,
    input  logic               vram_ack,
    output logic [7:0]         scroll_x,
    output logic [7:0]         scroll_y,
    output logic               fifo_overflow,
    output logic               irq
);

    localparam logic [3:0] REG_ADDR_LO  = 4'h0;
    localparam logic [3:0] REG_ADDR_HI  = 4'h1;
    localparam logic [3:0] REG_DATA     = 4'h2;
    localparam logic [3:0] REG_INCR     = 4'h3;
    localparam logic [3:0] REG_IRQ_EN   = 4'h4;
    localparam logic [3:0] REG_IRQ_CLR  = 4'h5;
    localparam logic [3:0] REG_SCROLL_X = 4'h6;
    localparam logic [3:0] REG_SCROLL_Y = 4'h7;

    // ------------------------------------------------------------------
    // Strobe synchroniser and bus capture
    // ------------------------------------------------------------------
    logic       cs_s1_q, cs_s2_q, cs_s3_q;
    logic       cs_rise;
    logic [3:0] bus_addr_q;
    logic [7:0] bus_data_q;
    logic       bus_rw_q;
    logic       act_q;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge CLK100MHz or negedge rst) begin
        if (!rst) begin
            cs_s1_q <= 1'b0;
            cs_s2_q <= 1'b0;
            cs_s3_q <= 1'b0;
        end else begin
            cs_s1_q <= cs_clock;
            cs_s2_q <= cs_s1_q;
            cs_s3_q <= cs_s2_q;
        end
    end

    assign cs_rise = cs_s2_q & ~cs_s3_q;

    // Latch the bus on the detected edge; the action fires the next cycle.
    always_ff @(posedge CLK100MHz or negedge rst) begin
        if (!rst) begin
            bus_addr_q <= '0;
            bus_data_q <= '0;
            bus_rw_q   <= 1'b0;
            act_q      <= 1'b0;
        end else begin
            act_q <= cs_rise;
            if (cs_rise) begin
                bus_addr_q <= addr;
                bus_data_q <= data;
                bus_rw_q   <= rw;
            end
        end
    end

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic               wr_en;
    logic [VRAM_AW-1:0] ptr_q, ptr_d;
    logic [7:0]         incr_q, incr_d;
    logic [7:0]         scroll_x_q, scroll_x_d;
    logic [7:0]         scroll_y_q, scroll_y_d;
    logic               irq_en_q, irq_en_d;
    logic               stat_q, stat_d;
    logic               ovf_q, ovf_d;
    logic               irq_q, irq_d;
    logic               vb_q;
    logic               vb_set;
    logic               push_q, push_d;
    logic [VRAM_AW-1:0] push_addr_q, push_addr_d;
    logic [7:0]         push_data_q, push_data_d;
    logic               push_drop;

    assign wr_en  = act_q & ~bus_rw_q;
    assign vb_set = vblank & ~vb_q;

    // Register decode and next-state for everything the CPU can write.
    always_comb begin
        ptr_d       = ptr_q;
        incr_d      = incr_q;
        scroll_x_d  = scroll_x_q;
        scroll_y_d  = scroll_y_q;
        irq_en_d    = irq_en_q;
        stat_d      = stat_q;
        ovf_d       = ovf_q;
        push_d      = 1'b0;
        push_addr_d = push_addr_q;
        push_data_d = push_data_q;
        if (wr_en) begin
            case (bus_addr_q)
                REG_ADDR_LO:  ptr_d = {ptr_q[VRAM_AW-1:8], bus_data_q};
                REG_ADDR_HI:  ptr_d = {bus_data_q[VRAM_AW-9:0], ptr_q[7:0]};
                REG_DATA: begin
                    push_d      = 1'b1;
                    push_addr_d = ptr_q;
                    push_data_d = bus_data_q;
                    ptr_d       = ptr_q + VRAM_AW'(incr_q);
                end
                REG_INCR:     incr_d     = bus_data_q;
                REG_IRQ_EN:   irq_en_d   = bus_data_q[0];
                REG_IRQ_CLR: begin
                    if (bus_data_q[0]) stat_d = 1'b0;
                    if (bus_data_q[7]) ovf_d  = 1'b0;
                end
                REG_SCROLL_X: scroll_x_d = bus_data_q;
                REG_SCROLL_Y: scroll_y_d = bus_data_q;
                default: ;
            endcase
        end
        // A new vblank edge or a dropped write beats a same-cycle clear.
        if (vb_set)    stat_d = 1'b1;
        if (push_drop) ovf_d  = 1'b1;
        irq_d = stat_q & irq_en_q;
    end

    // Register file state, including the one-cycle push staging register.
    always_ff @(posedge CLK100MHz or negedge rst) begin
        if (!rst) begin
            ptr_q       <= '0;
            incr_q      <= 8'd1;
            scroll_x_q  <= '0;
            scroll_y_q  <= '0;
            irq_en_q    <= 1'b0;
            stat_q      <= 1'b0;
            ovf_q       <= 1'b0;
            irq_q       <= 1'b0;
            vb_q        <= 1'b0;
            push_q      <= 1'b0;
            push_addr_q <= '0;
            push_data_q <= '0;
        end else begin
            ptr_q       <= ptr_d;
            incr_q      <= incr_d;
            scroll_x_q  <= scroll_x_d;
            scroll_y_q  <= scroll_y_d;
            irq_en_q    <= irq_en_d;
            stat_q      <= stat_d;
            ovf_q       <= ovf_d;
            irq_q       <= irq_d;
            vb_q        <= vblank;
            push_q      <= push_d;
            push_addr_q <= push_addr_d;
            push_data_q <= push_data_d;
        end
    end

    assign scroll_x      = scroll_x_q;
    assign scroll_y      = scroll_y_q;
    assign fifo_overflow = ovf_q;
    assign irq           = irq_q;

    // ------------------------------------------------------------------
    // VRAM write queue
    // ------------------------------------------------------------------
`ifdef GPU_WRITE_FIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);

    logic [VRAM_AW-1:0] fa_q [FIFO_DEPTH];
    logic [7:0]         fd_q [FIFO_DEPTH];
    logic [PW-1:0]      wp_q, rp_q;
    logic [PW:0]        cnt_q;
    logic               full, empty, pop, push_ok;

    assign full      = (cnt_q == (PW+1)'(FIFO_DEPTH));
    assign empty     = (cnt_q == '0);
    assign pop       = vram_ack & ~empty;
    assign push_ok   = push_q & (~full | pop);
    assign push_drop = push_q & full & ~pop;

    // Circular buffer; a push into a full queue is allowed when the head pops.
    always_ff @(posedge CLK100MHz or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fa_q[i] <= '0;
                fd_q[i] <= '0;
            end
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) begin
                fa_q[wp_q] <= push_addr_q;
                fd_q[wp_q] <= push_data_q;
                wp_q       <= wp_q + PW'(1);
            end
            if (pop) rp_q <= rp_q + PW'(1);
            if (push_ok && !pop)      cnt_q <= cnt_q + (PW+1)'(1);
            else if (pop && !push_ok) cnt_q <= cnt_q - (PW+1)'(1);
        end
    end

    assign vram_wr_addr = fa_q[rp_q];
    assign vram_wr_data = fd_q[rp_q];
    assign vram_we      = ~empty;
`else
    logic               hold_v_q;
    logic [VRAM_AW-1:0] hold_a_q;
    logic [7:0]         hold_d_q;
    logic               pop, push_ok;

    assign pop       = vram_ack & hold_v_q;
    assign push_ok   = push_q & (~hold_v_q | pop);
    assign push_drop = push_q & hold_v_q & ~pop;

    // Single holding register; refilled in the same cycle it is acked.
    always_ff @(posedge CLK100MHz or negedge rst) begin
        if (!rst) begin
            hold_v_q <= 1'b0;
            hold_a_q <= '0;
            hold_d_q <= '0;
        end else begin
            if (push_ok) begin
                hold_v_q <= 1'b1;
                hold_a_q <= push_addr_q;
                hold_d_q <= push_data_q;
            end else if (pop) begin
                hold_v_q <= 1'b0;
            end
        end
    end

    assign vram_wr_addr = hold_a_q;
    assign vram_wr_data = hold_d_q;
    assign vram_we      = hold_v_q;
`endif

endmodule

// File: tb/tb_gpu_bus_interface.sv
// Directed bench for gpu_bus_interface: a table of single register writes
// followed by hand-written multi-cycle sequences.
module tb_gpu_bus_interface;

`ifdef GPU_WRITE_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  data = '0;
    logic [3:0]  addr = '0;
    logic        rw = 1'b0;
    logic        cs = 1'b0;
    logic        vblank = 1'b0;
    logic [12:0] vram_wr_addr;
    logic [7:0]  vram_wr_data;
    logic        vram_we;
    logic        vram_ack = 1'b0;
    logic [7:0]  scroll_x, scroll_y;
    logic        fifo_overflow;
    logic        irq;

    int n_vec = 0;
    int n_bad = 0;

    gpu_bus_interface #(.VRAM_AW(13), .FIFO_DEPTH(4)) dut (
        .CLK100MHz     (clk),
        .rst           (rst),
        .data          (data),
        .addr          (addr),
        .rw            (rw),
        .cs_clock      (cs),
        .vblank        (vblank),
        .vram_wr_addr  (vram_wr_addr),
        .vram_wr_data  (vram_wr_data),
        .vram_we       (vram_we),
        .vram_ack      (vram_ack),
        .scroll_x      (scroll_x),
        .scroll_y      (scroll_y),
        .fifo_overflow (fifo_overflow),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  a;
        logic [7:0]  d;
        logic [7:0]  sx;
        logic [7:0]  sy;
        logic        we;
        logic [12:0] wa;
        logic [7:0]  wd;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic strobe(input logic [3:0] a, input logic [7:0] d, input logic r, input int hold);
        @(negedge clk);
        addr = a; data = d; rw = r; cs = 1'b1;
        repeat (hold) @(negedge clk);
        cs = 1'b0;
        repeat (3) @(negedge clk);
        rw = 1'b0;
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        strobe(a, d, 1'b0, 4);
    endtask

    task automatic ack_pulse();
        @(negedge clk) vram_ack = 1'b1;
        @(negedge clk) vram_ack = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk) rst = 1'b0;
        cs = 1'b0; vram_ack = 1'b0; vblank = 1'b0; rw = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, "_we"},   vram_we, 1'b0);
        chk({nm, "_wa"},   vram_wr_addr, 13'h0);
        chk({nm, "_wd"},   vram_wr_data, 8'h0);
        chk({nm, "_sx"},   scroll_x, 8'h0);
        chk({nm, "_sy"},   scroll_y, 8'h0);
        chk({nm, "_ovf"},  fifo_overflow, 1'b0);
        chk({nm, "_irq"},  irq, 1'b0);
    endtask

    initial begin
        //          addr   data   sx     sy     we    wa        wd
        tbl[0] = '{4'h6, 8'h37, 8'h37, 8'h00, 1'b0, 13'h0000, 8'h00};
        tbl[1] = '{4'h7, 8'hC5, 8'h37, 8'hC5, 1'b0, 13'h0000, 8'h00};
        tbl[2] = '{4'h8, 8'hFF, 8'h37, 8'hC5, 1'b0, 13'h0000, 8'h00};
        tbl[3] = '{4'hF, 8'h12, 8'h37, 8'hC5, 1'b0, 13'h0000, 8'h00};
        tbl[4] = '{4'h0, 8'h34, 8'h37, 8'hC5, 1'b0, 13'h0000, 8'h00};
        tbl[5] = '{4'h1, 8'hE2, 8'h37, 8'hC5, 1'b0, 13'h0000, 8'h00};
        tbl[6] = '{4'hA, 8'h05, 8'h37, 8'hC5, 1'b0, 13'h0000, 8'h00};
        tbl[7] = '{4'h2, 8'h99, 8'h37, 8'hC5, 1'b1, 13'h0234, 8'h99};

        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("reset");

        // Table-driven single writes
        for (int i = 0; i < 8; i++) begin
            cpu_wr(tbl[i].a, tbl[i].d);
            chk($sformatf("tbl%0d_sx", i), scroll_x, tbl[i].sx);
            chk($sformatf("tbl%0d_sy", i), scroll_y, tbl[i].sy);
            chk($sformatf("tbl%0d_we", i), vram_we, tbl[i].we);
            if (tbl[i].we) begin
                chk($sformatf("tbl%0d_wa", i), vram_wr_addr, tbl[i].wa);
                chk($sformatf("tbl%0d_wd", i), vram_wr_data, tbl[i].wd);
            end
        end
        // Default INCR=1: next DATA lands at 0x0235
        ack_pulse();
        chk("incr1_pop_we", vram_we, 1'b0);
        cpu_wr(4'h2, 8'h11);
        chk("incr1_wa", vram_wr_addr, 13'h0235);
        chk("incr1_wd", vram_wr_data, 8'h11);
        ack_pulse();

        do_reset();
        chk_idle("reset2");

        // Wrap with INCR=2 and exact vram_we latency
        cpu_wr(4'h3, 8'h02);
        cpu_wr(4'h0, 8'hFE);
        cpu_wr(4'h1, 8'h1F);
        @(negedge clk);
        addr = 4'h2; data = 8'hAA; rw = 1'b0; cs = 1'b1;
        @(posedge clk);                 // edge N: strobe first sampled
        repeat (3) @(posedge clk);      // edge N+3
        #1 chk("lat_we_n3", vram_we, 1'b0);
        @(posedge clk);                 // edge N+4
        #1 chk("lat_we_n4", vram_we, 1'b1);
        @(negedge clk) cs = 1'b0;
        repeat (2) @(negedge clk);
        chk("wrap0_wa", vram_wr_addr, 13'h1FFE);
        chk("wrap0_wd", vram_wr_data, 8'hAA);
        ack_pulse();
        chk("wrap0_pop", vram_we, 1'b0);
        cpu_wr(4'h2, 8'h55);
        chk("wrap1_we", vram_we, 1'b1);
        chk("wrap1_wa", vram_wr_addr, 13'h0000);
        chk("wrap1_wd", vram_wr_data, 8'h55);
        repeat (2) @(negedge clk);
        ack_pulse();
        chk("wrap1_pop", vram_we, 1'b0);

        // Overflow: DEPTH+1 writes with ack held low
        cpu_wr(4'h3, 8'h01);
        cpu_wr(4'h0, 8'h10);
        cpu_wr(4'h1, 8'h00);
        for (int k = 0; k <= DEPTH; k++) cpu_wr(4'h2, 8'(k + 1));
        chk("ovf_flag", fifo_overflow, 1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            chk($sformatf("drain%0d_we", k), vram_we, 1'b1);
            chk($sformatf("drain%0d_wa", k), vram_wr_addr, 13'(16 + k));
            chk($sformatf("drain%0d_wd", k), vram_wr_data, 8'(k + 1));
            ack_pulse();
        end
        chk("drain_empty", vram_we, 1'b0);
        chk("ovf_sticky", fifo_overflow, 1'b1);
        cpu_wr(4'h5, 8'h80);
        chk("ovf_clr", fifo_overflow, 1'b0);

        // Push coinciding with ack of the only queued entry is accepted
        cpu_wr(4'h2, 8'h61);
        chk("coin0_wa", vram_wr_addr, 13'(16 + DEPTH + 1));
        @(negedge clk);
        addr = 4'h2; data = 8'h62; rw = 1'b0; cs = 1'b1;
        repeat (3) @(negedge clk);
        @(negedge clk);                 // N+3.5: ack sampled at N+4 with the push
        vram_ack = 1'b1; cs = 1'b0;
        @(negedge clk) vram_ack = 1'b0;
        repeat (2) @(negedge clk);
        chk("coin_ovf", fifo_overflow, 1'b0);
        chk("coin_we", vram_we, 1'b1);
        chk("coin_wa", vram_wr_addr, 13'(16 + DEPTH + 2));
        chk("coin_wd", vram_wr_data, 8'h62);
        ack_pulse();
        chk("coin_empty", vram_we, 1'b0);

        // Interrupt
        cpu_wr(4'h4, 8'h01);
        chk("irq_en_idle", irq, 1'b0);
        @(negedge clk) vblank = 1'b1;
        @(posedge clk);
        #1 chk("irq_edge0", irq, 1'b0);
        @(posedge clk);
        #1 chk("irq_edge1", irq, 1'b1);
        @(negedge clk) vblank = 1'b0;
        repeat (3) @(negedge clk);
        @(negedge clk);
        addr = 4'h5; data = 8'h01; rw = 1'b0; cs = 1'b1;
        repeat (2) @(negedge clk);
        @(negedge clk) vblank = 1'b1;   // N+2.5: new edge lands with the clear
        @(negedge clk) cs = 1'b0;
        @(negedge clk) chk("irq_setwins_a", irq, 1'b1);
        @(negedge clk) chk("irq_setwins_b", irq, 1'b1);
        vblank = 1'b0;
        cpu_wr(4'h4, 8'h00);
        chk("irq_masked", irq, 1'b0);
        cpu_wr(4'h4, 8'h01);
        chk("irq_unmasked", irq, 1'b1);
        cpu_wr(4'h5, 8'h01);
        chk("irq_cleared", irq, 1'b0);

        // Read strobe ignored; long strobes act once
        do_reset();
        strobe(4'h2, 8'h77, 1'b1, 4);
        chk("rd_no_push", vram_we, 1'b0);
        strobe(4'h6, 8'h37, 1'b0, 80);
        chk("long_sx", scroll_x, 8'h37);
        strobe(4'h2, 8'h5A, 1'b0, 80);
        chk("long_we", vram_we, 1'b1);
        chk("long_wd", vram_wr_data, 8'h5A);
        ack_pulse();
        chk("long_single", vram_we, 1'b0);
        chk("long_no_ovf", fifo_overflow, 1'b0);

        // Asynchronous reset with entries queued
        cpu_wr(4'h0, 8'h40);
        for (int k = 0; k < 3; k++) cpu_wr(4'h2, 8'(8'hC0 + k));
        chk("arst_pre_we", vram_we, 1'b1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("arst_we_drop", vram_we, 1'b0);
        chk("arst_sx", scroll_x, 8'h00);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("arst_post_we", vram_we, 1'b0);
        chk("arst_post_ovf", fifo_overflow, 1'b0);
        ack_pulse();                    // ack with nothing queued is ignored
        chk("ack_idle_we", vram_we, 1'b0);
        cpu_wr(4'h2, 8'hAB);
        chk("ptr0_wa", vram_wr_addr, 13'h0000);
        chk("ptr0_wd", vram_wr_data, 8'hAB);
        ack_pulse();

        // INCR=0 holds the pointer
        cpu_wr(4'h3, 8'h00);
        cpu_wr(4'h2, 8'hCD);
        chk("inc0_a_wa", vram_wr_addr, 13'h0001);
        chk("inc0_a_wd", vram_wr_data, 8'hCD);
        ack_pulse();
        cpu_wr(4'h2, 8'hEF);
        chk("inc0_b_wa", vram_wr_addr, 13'h0001);
        chk("inc0_b_wd", vram_wr_data, 8'hEF);
        ack_pulse();
        chk("inc0_empty", vram_we, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
